// File: rtl/puf_stream_engine.sv
// puf_stream_engine: descriptor-driven word stream engine.
// Reads LENGTH words, transforms them by MODE, writes them out, posts STATUS.
module puf_stream_engine #(
  parameter int BYTE_WIDTH           = 1,
  parameter int INMEM_ADDRESS_WIDTH  = 17,
  parameter int OUTMEM_ADDRESS_WIDTH = 13,
  parameter int FIFO_DEPTH_LOG2      = 2,
  parameter int RAND_ADDR_WIDTH      = 13
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            userRunValue,
  output logic                            userRunClear,
  output logic                            register32CmdReq,
  input  logic                            register32CmdAck,
  output logic                            register32WriteEn,
  output logic [7:0]                      register32Address,
  output logic [31:0]                     register32WriteData,
  input  logic                            register32ReadDataValid,
  input  logic [31:0]                     register32ReadData,
  output logic                            inputMemoryReadReq,
  input  logic                            inputMemoryReadAck,
  output logic [INMEM_ADDRESS_WIDTH-1:0]  inputMemoryReadAdd,
  input  logic                            inputMemoryReadDataValid,
  input  logic [8*BYTE_WIDTH-1:0]         inputMemoryReadData,
  output logic                            outputMemoryWriteReq,
  input  logic                            outputMemoryWriteAck,
  output logic [OUTMEM_ADDRESS_WIDTH-1:0] outputMemoryWriteAdd,
  output logic [8*BYTE_WIDTH-1:0]         outputMemoryWriteData,
  output logic [BYTE_WIDTH-1:0]           outputMemoryWriteByteMask,
  input  logic [8*BYTE_WIDTH-1:0]         randData,
  output logic [RAND_ADDR_WIDTH-1:0]      randAddr
);
  localparam int DW  = 8 * BYTE_WIDTH;
  localparam int IAW = INMEM_ADDRESS_WIDTH;
  localparam int OAW = OUTMEM_ADDRESS_WIDTH;
  localparam int RAW = RAND_ADDR_WIDTH;
  localparam int PW  = FIFO_DEPTH_LOG2;
  localparam int CW  = FIFO_DEPTH_LOG2 + 1;
  localparam int CW1 = CW + 1;
  localparam int D   = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, READ_PARAMS, RUN, WRITE_STATUS} state_t;

  state_t          state_q, state_d;
  logic [31:0]     len_q, len_d;
  logic [1:0]      mode_q, mode_d;
  logic [DW-1:0]   opnd_q, opnd_d;
  logic [1:0]      prm_q, prm_d;
  logic [31:0]     issued_q, issued_d;
  logic [31:0]     words_q, words_d;
  logic [CW-1:0]   pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic            clr_q, clr_d;
  logic            cmd_q, cmd_d;
  logic            we_q, we_d;
  logic [7:0]      radr_q, radr_d;
  logic [31:0]     wdat_q, wdat_d;
  logic            in_req_q, in_req_d;
  logic [IAW-1:0]  in_add_q, in_add_d;
  logic            out_req_q, out_req_d;
  logic [OAW-1:0]  out_add_q, out_add_d;
  logic [DW-1:0]   out_dat_q, out_dat_d;
  logic [RAW-1:0]  rnd_q, rnd_d;
  logic [DW-1:0]   fifo_mem [D];

  logic            reg_acc, rd_acc, wr_acc;
  logic            push, pop;
  logic [DW-1:0]   head, xform;
  logic [CW:0]     credit;
  logic            unused_rd;

  assign reg_acc = cmd_q & register32CmdAck;
  assign rd_acc  = in_req_q & inputMemoryReadAck;
  assign wr_acc  = out_req_q & outputMemoryWriteAck;
  assign push    = (state_q == RUN) & inputMemoryReadDataValid;
  assign pop     = (state_q == RUN) & ((cnt_q != '0) | push)
                 & (~out_req_q | wr_acc);
  // an empty FIFO passes the arriving word straight through
  assign head    = (cnt_q == '0) ? inputMemoryReadData
                                 : fifo_mem[rptr_q];
  assign unused_rd = ^register32ReadData;

  // word transform selected by MODE
  always_comb begin
    xform = head;
    unique case (mode_q)
      2'd0: xform = head;
      2'd1: xform = head * opnd_q;
      2'd2: xform = head ^ randData;
      2'd3: xform = randData ^ opnd_q;
    endcase
  end

  // next-state logic for the control FSM, credits and output regs
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    mode_d    = mode_q;
    opnd_d    = opnd_q;
    prm_d     = prm_q;
    issued_d  = issued_q;
    words_d   = words_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    clr_d     = clr_q;
    cmd_d     = cmd_q;
    we_d      = we_q;
    radr_d    = radr_q;
    wdat_d    = wdat_q;
    in_req_d  = in_req_q;
    in_add_d  = in_add_q;
    out_req_d = out_req_q;
    out_add_d = out_add_q;
    out_dat_d = out_dat_q;
    rnd_d     = rnd_q;
    credit    = '0;
    unique case (state_q)
      IDLE: begin
        clr_d = 1'b0;
        if (userRunValue && !clr_q) begin
          state_d = READ_PARAMS;
          radr_d  = 8'd0;
          we_d    = 1'b0;
          cmd_d   = 1'b1;
          prm_d   = 2'd0;
        end
      end
      READ_PARAMS: begin
        if (reg_acc) begin
          radr_d = radr_q + 8'd1;
          if (radr_q == 8'd2) cmd_d = 1'b0;
        end
        if (register32ReadDataValid) begin
          prm_d = prm_q + 2'd1;
          case (prm_q)
            2'd0:    len_d  = register32ReadData;
            2'd1:    mode_d = register32ReadData[1:0];
            default: opnd_d = DW'(register32ReadData);
          endcase
          if (prm_q == 2'd2) begin
            in_add_d  = '0;
            out_add_d = '0;
            rnd_d     = '0;
            words_d   = '0;
            issued_d  = '0;
            if (len_q == 32'd0) begin
              state_d = WRITE_STATUS;
              cmd_d   = 1'b1;
              we_d    = 1'b1;
              radr_d  = 8'd3;
              wdat_d  = {1'b1, mode_q, 29'd0};
            end else begin
              state_d  = RUN;
              in_req_d = 1'b1;
            end
          end
        end
      end
      RUN: begin
        if (rd_acc) begin
          issued_d = issued_q + 32'd1;
          in_add_d = in_add_q + IAW'(1);
        end
        pend_d = pend_q + CW'(rd_acc) - CW'(push);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        credit   = {1'b0, pend_d} + {1'b0, cnt_d};
        in_req_d = (issued_d != len_q) && (credit < CW1'(D));
        if (wr_acc) begin
          words_d   = words_q + 32'd1;
          out_req_d = 1'b0;
          if (words_d != len_q) out_add_d = out_add_q + OAW'(1);
        end
        if (pop) begin
          out_req_d = 1'b1;
          out_dat_d = xform;
          rnd_d     = rnd_q + RAW'(1);
        end
        if (wr_acc && (words_d == len_q)) begin
          state_d = WRITE_STATUS;
          cmd_d   = 1'b1;
          we_d    = 1'b1;
          radr_d  = 8'd3;
          wdat_d  = {1'b1, mode_q, words_d[28:0]};
        end
      end
      WRITE_STATUS: begin
        if (reg_acc) begin
          cmd_d   = 1'b0;
          we_d    = 1'b0;
          clr_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      mode_q    <= '0;
      opnd_q    <= '0;
      prm_q     <= '0;
      issued_q  <= '0;
      words_q   <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      clr_q     <= 1'b0;
      cmd_q     <= 1'b0;
      we_q      <= 1'b0;
      radr_q    <= '0;
      wdat_q    <= '0;
      in_req_q  <= 1'b0;
      in_add_q  <= '0;
      out_req_q <= 1'b0;
      out_add_q <= '0;
      out_dat_q <= '0;
      rnd_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      opnd_q    <= opnd_d;
      prm_q     <= prm_d;
      issued_q  <= issued_d;
      words_q   <= words_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      clr_q     <= clr_d;
      cmd_q     <= cmd_d;
      we_q      <= we_d;
      radr_q    <= radr_d;
      wdat_q    <= wdat_d;
      in_req_q  <= in_req_d;
      in_add_q  <= in_add_d;
      out_req_q <= out_req_d;
      out_add_q <= out_add_d;
      out_dat_q <= out_dat_d;
      rnd_q     <= rnd_d;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= inputMemoryReadData;
  end

  fifo_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(push && (cnt_q == CW'(D))));

  assign userRunClear              = clr_q;
  assign register32CmdReq          = cmd_q;
  assign register32WriteEn         = we_q;
  assign register32Address         = radr_q;
  assign register32WriteData       = wdat_q;
  assign inputMemoryReadReq        = in_req_q;
  assign inputMemoryReadAdd        = in_add_q;
  assign outputMemoryWriteReq      = out_req_q;
  assign outputMemoryWriteAdd      = out_add_q;
  assign outputMemoryWriteData     = out_dat_q;
  assign outputMemoryWriteByteMask = '1;
  assign randAddr                  = rnd_q;

endmodule

// File: tb/tb_puf_stream_engine.sv
// tb_puf_stream_engine: randomized bench with memory/regfile responders
// and a behavioural word-level model of the stream engine.
module tb_puf_stream_engine;
  localparam int DW  = 8;
  localparam int IAW = 17;
  localparam int OAW = 13;
  localparam int RAW = 13;
  localparam int D   = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           userRunValue = 1'b0;
  logic           userRunClear;
  logic           register32CmdReq;
  logic           register32CmdAck = 1'b0;
  logic           register32WriteEn;
  logic [7:0]     register32Address;
  logic [31:0]    register32WriteData;
  logic           register32ReadDataValid = 1'b0;
  logic [31:0]    register32ReadData = '0;
  logic           inputMemoryReadReq;
  logic           inputMemoryReadAck = 1'b0;
  logic [IAW-1:0] inputMemoryReadAdd;
  logic           inputMemoryReadDataValid = 1'b0;
  logic [DW-1:0]  inputMemoryReadData = '0;
  logic           outputMemoryWriteReq;
  logic           outputMemoryWriteAck = 1'b0;
  logic [OAW-1:0] outputMemoryWriteAdd;
  logic [DW-1:0]  outputMemoryWriteData;
  logic [0:0]     outputMemoryWriteByteMask;
  logic [DW-1:0]  randData;
  logic [RAW-1:0] randAddr;

  puf_stream_engine dut (
    .clk                       (clk),
    .reset                     (reset),
    .userRunValue              (userRunValue),
    .userRunClear              (userRunClear),
    .register32CmdReq          (register32CmdReq),
    .register32CmdAck          (register32CmdAck),
    .register32WriteEn         (register32WriteEn),
    .register32Address         (register32Address),
    .register32WriteData       (register32WriteData),
    .register32ReadDataValid   (register32ReadDataValid),
    .register32ReadData        (register32ReadData),
    .inputMemoryReadReq        (inputMemoryReadReq),
    .inputMemoryReadAck        (inputMemoryReadAck),
    .inputMemoryReadAdd        (inputMemoryReadAdd),
    .inputMemoryReadDataValid  (inputMemoryReadDataValid),
    .inputMemoryReadData       (inputMemoryReadData),
    .outputMemoryWriteReq      (outputMemoryWriteReq),
    .outputMemoryWriteAck      (outputMemoryWriteAck),
    .outputMemoryWriteAdd      (outputMemoryWriteAdd),
    .outputMemoryWriteData     (outputMemoryWriteData),
    .outputMemoryWriteByteMask (outputMemoryWriteByteMask),
    .randData                  (randData),
    .randAddr                  (randAddr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  logic [7:0]  in_mem   [256];
  logic [7:0]  rand_mem [8192];
  logic [31:0] regs     [4];
  assign randData = rand_mem[randAddr];

  rsp_t        reg_q[$];
  rsp_t        in_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  out_seen[$];
  logic [7:0]  rd_addr_q[$];

  int lat = 2;
  int reg_pct = 100, in_pct = 100, out_pct = 100, out_stall = 0;
  int n_in_req, n_in_acc, n_out_acc, n_status, n_clr, max_outst;
  int first_in_acc, first_out_req, first_out_acc, last_out_acc;
  logic [31:0] status_addr, status_data;

  int pass_n = 0;
  int total_n = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] model(input logic [7:0] w, input int mode,
                                       input logic [7:0] op,
                                       input logic [7:0] r);
    case (mode)
      0:       return w;
      1:       return 8'((int'(w) * int'(op)) % 256);
      2:       return w ^ r;
      default: return r ^ op;
    endcase
  endfunction

  // register file responder
  initial forever begin
    @(negedge clk);
    if (reset) begin
      reg_q.delete();
      register32CmdAck = 1'b0;
      register32ReadDataValid = 1'b0;
    end else begin
      register32ReadDataValid = 1'b0;
      if (reg_q.size() > 0 && reg_q[0].due <= cyc) begin
        register32ReadDataValid = 1'b1;
        register32ReadData = reg_q[0].d;
        void'(reg_q.pop_front());
      end
      register32CmdAck = ($urandom_range(99) < reg_pct);
      if (register32CmdReq && register32CmdAck) begin
        if (register32WriteEn) begin
          n_status++;
          status_addr = 32'(register32Address);
          status_data = register32WriteData;
        end else begin
          rd_addr_q.push_back(register32Address);
          reg_q.push_back('{cyc + lat, regs[register32Address[1:0]]});
        end
      end
    end
  end

  // input memory responder, in-order with fixed latency
  initial forever begin
    @(negedge clk);
    if (reset) begin
      in_q.delete();
      inputMemoryReadAck = 1'b0;
      inputMemoryReadDataValid = 1'b0;
    end else begin
      inputMemoryReadDataValid = 1'b0;
      if (in_q.size() > 0 && in_q[0].due <= cyc) begin
        inputMemoryReadDataValid = 1'b1;
        inputMemoryReadData = in_q[0].d[7:0];
        void'(in_q.pop_front());
      end
      inputMemoryReadAck = ($urandom_range(99) < in_pct);
      if (inputMemoryReadReq) n_in_req++;
      if (inputMemoryReadReq && inputMemoryReadAck) begin
        if (first_in_acc < 0) first_in_acc = cyc;
        n_in_acc++;
        in_q.push_back('{cyc + lat,
                         32'(in_mem[inputMemoryReadAdd[7:0]])});
      end
    end
  end

  // output memory responder and the per-word compare against the model
  initial forever begin
    @(negedge clk);
    if (reset) begin
      outputMemoryWriteAck = 1'b0;
    end else begin
      if (outputMemoryWriteReq && first_out_req < 0) first_out_req = cyc;
      outputMemoryWriteAck = (first_out_req >= 0)
                          && (cyc >= first_out_req + out_stall)
                          && ($urandom_range(99) < out_pct);
      if (outputMemoryWriteReq && outputMemoryWriteAck) begin
        check("out_addr", outputMemoryWriteAdd, 13'(n_out_acc));
        if (exp_q.size() == 0)
          check("out_extra_word", outputMemoryWriteData, 64'hDEAD);
        else
          check("out_data", outputMemoryWriteData, exp_q.pop_front());
        out_seen.push_back(outputMemoryWriteData);
        if (first_out_acc < 0) first_out_acc = cyc;
        last_out_acc = cyc;
        n_out_acc++;
      end
    end
  end

  // run-clear pulse counter
  initial forever begin
    @(negedge clk);
    if (!reset && userRunClear) n_clr++;
  end

  // words read but not yet written never exceed FIFO depth + output reg
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset && (n_in_acc - n_out_acc) > max_outst)
      max_outst = n_in_acc - n_out_acc;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_run(input int len, input int mode,
                           input logic [7:0] opv, input int ip,
                           input int opc, input int stall);
    logic [31:0] r;
    r = $urandom;
    regs[0] = 32'(len);
    regs[1] = {r[31:2], 2'(mode)};
    r = $urandom;
    regs[2] = {r[31:8], opv};
    regs[3] = '0;
    exp_q.delete();
    out_seen.delete();
    rd_addr_q.delete();
    for (int i = 0; i < len; i++)
      exp_q.push_back(model(in_mem[i], mode, opv, rand_mem[i]));
    n_in_req = 0; n_in_acc = 0; n_out_acc = 0;
    n_status = 0; n_clr = 0; max_outst = 0;
    status_addr = '0; status_data = '0;
    first_in_acc = -1; first_out_req = -1;
    first_out_acc = -1; last_out_acc = -1;
    in_pct = ip; out_pct = opc; out_stall = stall;
    @(negedge clk);
    userRunValue = 1'b1;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!userRunClear && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("run_done", userRunClear, 1);
    @(posedge clk);
    #1;
    userRunValue = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic end_checks(input int len, input int mode);
    logic [23:0] pr;
    pr = (rd_addr_q.size() == 3) ?
         {rd_addr_q[0], rd_addr_q[1], rd_addr_q[2]} : 24'hFFFFFF;
    check("word_count", n_out_acc, len);
    check("status_writes", n_status, 1);
    check("status_addr", status_addr, 3);
    check("status_data", status_data, {1'b1, 2'(mode), 29'(len)});
    check("clear_pulses", n_clr, 1);
    check("param_read_order", pr, 24'h000102);
    check("rand_addr_end", randAddr, 13'(len));
    check("byte_mask", outputMemoryWriteByteMask, 1);
    check("credit_bound", (max_outst <= D + 1), 1);
  endtask

  function automatic logic [63:0] reg_side();
    return {21'd0, userRunClear, register32CmdReq, register32WriteEn,
            register32Address, register32WriteData};
  endfunction

  function automatic logic [63:0] mem_side();
    return {11'd0, inputMemoryReadReq, inputMemoryReadAdd,
            outputMemoryWriteReq, outputMemoryWriteAdd,
            outputMemoryWriteData, randAddr};
  endfunction

  initial begin
    int len, mode;
    logic [7:0] opv;
    int t;
    for (int i = 0; i < 256; i++) in_mem[i] = 8'($urandom);
    for (int i = 0; i < 8192; i++) rand_mem[i] = 8'($urandom);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_reg_side", reg_side(), 0);
    check("reset_mem_side", mem_side(), 0);
    check("reset_byte_mask", outputMemoryWriteByteMask, 1);
    reset = 1'b0;
    @(negedge clk);

    // copy mode, full-rate handshakes
    for (int i = 0; i < 8; i++) in_mem[i] = 8'(8'h10 + i);
    lat = 2; reg_pct = 100;
    start_run(8, 0, 8'h00, 100, 100, 0);
    wait_done();
    end_checks(8, 0);
    check("t1_status", status_data, 32'h80000008);
    for (int i = 0; i < 8; i++)
      check("t1_out_word", out_seen[i], 8'h10 + i);
    check("t1_latency", first_out_req - first_in_acc, lat + 1);
    check("t1_throughput", last_out_acc - first_out_acc, 7);

    // multiply mode
    reg_pct = 70;
    in_mem[0] = 8'h90;
    start_run(1, 1, 8'h03, 100, 100, 0);
    wait_done();
    end_checks(1, 1);
    check("t2_mult", out_seen[0], 8'hB0);

    // XOR with constant PUF data
    for (int i = 0; i < 8192; i++) rand_mem[i] = 8'hA5;
    for (int i = 0; i < 4; i++) in_mem[i] = 8'h0F;
    start_run(4, 2, 8'($urandom), 100, 100, 0);
    wait_done();
    end_checks(4, 2);
    for (int i = 0; i < 4; i++) check("t3_xor", out_seen[i], 8'hAA);
    check("t3_rand_addr", randAddr, 4);
    for (int i = 0; i < 8192; i++) rand_mem[i] = 8'($urandom);

    // back-pressure: slow input acks, long output stall
    for (int i = 0; i < 20; i++) in_mem[i] = 8'($urandom);
    lat = 3;
    mode = $urandom_range(0, 3);
    start_run(20, mode, 8'($urandom), 50, 100, 30);
    wait_done();
    end_checks(20, mode);
    check("t4_credit_full", max_outst, D + 1);

    // zero length
    lat = 2;
    start_run(0, 0, 8'h00, 100, 100, 0);
    wait_done();
    end_checks(0, 0);
    check("t5_status", status_data, 32'h80000000);
    check("t5_no_reads", n_in_req, 0);

    // reset in the middle of a run
    for (int i = 0; i < 16; i++) in_mem[i] = 8'($urandom);
    start_run(10, 1, 8'($urandom), 100, 70, 0);
    t = 0;
    while (n_out_acc < 5 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("t6_reached_5", (n_out_acc >= 5), 1);
    reset = 1'b1;
    userRunValue = 1'b0;
    @(negedge clk);
    check("t6_reset_reg_side", reg_side(), 0);
    check("t6_reset_mem_side", mem_side(), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_no_status", n_status, 0);
    check("t6_no_clear", n_clr, 0);
    for (int i = 0; i < 3; i++) in_mem[i] = 8'($urandom);
    mode = $urandom_range(0, 3);
    start_run(3, mode, 8'($urandom), 100, 100, 0);
    wait_done();
    end_checks(3, mode);

    // randomized runs
    for (int k = 0; k < 5; k++) begin
      len  = $urandom_range(1, 24);
      mode = $urandom_range(0, 3);
      opv  = 8'($urandom);
      lat  = $urandom_range(1, 4);
      reg_pct = $urandom_range(30, 100);
      for (int i = 0; i < len; i++) in_mem[i] = 8'($urandom);
      start_run(len, mode, opv, $urandom_range(30, 100),
                $urandom_range(30, 100), $urandom_range(0, 10));
      wait_done();
      end_checks(len, mode);
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/puf_stream_engine.md
Name: puf_stream_engine

Overview:
- Parametrised successor to the single-mode user test module.
- Reads a run descriptor from the parameter register file and streams LENGTH words from input memory through a credit-controlled FIFO of configurable depth.
- Transforms each word by one of four modes (copy, multiply, XOR with PUF random data, PUF substitution) and writes it to output memory.
- On completion, writes a status word back to the register file, then clears the run register.

Parameters:
BYTE_WIDTH, 1, bytes per input/output memory word (power of 2 >= 1); DW = 8*BYTE_WIDTH
INMEM_ADDRESS_WIDTH, 17, input memory word-address width
OUTMEM_ADDRESS_WIDTH, 13, output memory word-address width
FIFO_DEPTH_LOG2, 2, log2 of input FIFO depth (depth D = 2^FIFO_DEPTH_LOG2, >= 2)
RAND_ADDR_WIDTH, 13, PUF random-source address width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
userRunValue  in  1  run register value
userRunClear  out  1  pulse to clear run register
register32CmdReq  out  1  register file request
register32CmdAck  in  1  register file accept (req&ack = accepted)
register32WriteEn  out  1  1 = write request, 0 = read request
register32Address  out  8  register file address
register32WriteData  out  32  register write data
register32ReadDataValid  in  1  read data returned
register32ReadData  in  32  read data
inputMemoryReadReq  out  1  input read request
inputMemoryReadAck  in  1  input read accept
inputMemoryReadAdd  out  INMEM_ADDRESS_WIDTH  input read address
inputMemoryReadDataValid  in  1  input read data valid
inputMemoryReadData  in  DW  input read data
outputMemoryWriteReq  out  1  output write request
outputMemoryWriteAck  in  1  output write accept
outputMemoryWriteAdd  out  OUTMEM_ADDRESS_WIDTH  output write address
outputMemoryWriteData  out  DW  output write data
outputMemoryWriteByteMask  out  BYTE_WIDTH  constant all ones
randData  in  DW  PUF random word at randAddr (combinational, same cycle)
randAddr  out  RAND_ADDR_WIDTH  PUF random address

Behaviour:
- Reset: all outputs 0 except ByteMask (all ones); state IDLE; FIFO empty; pending-read count 0. Reset mid-run aborts immediately; no status write, no userRunClear.
- Register map: addr0 = LENGTH, addr1 = MODE[1:0] (upper bits ignored), addr2 = OPERAND[DW-1:0], addr3 = STATUS (written).
- IDLE: userRunClear <= 0. When userRunValue=1 and userRunClear=0, go to READ_PARAMS with address 0, WriteEn 0, CmdReq 1.
- READ_PARAMS:
  - Address increments on each accepted read; CmdReq drops after address 2 is accepted.
  - Returned data is stored in arrival order to LENGTH, MODE, OPERAND.
  - When the third read returns: inputMemoryReadAdd, outputMemoryWriteAdd and randAddr are set to 0, and the word counter is cleared.
  - If LENGTH = 0, go straight to WRITE_STATUS; otherwise go to RUN.
- RUN, input side:
  - Request a read when pending + fifoCount < D and not all LENGTH reads have been issued.
  - Address increments per accepted read. inputDone is set when the read at LENGTH-1 is accepted.
  - Pending count is +1 on accept and -1 on valid (net 0 if both occur).
  - The FIFO never overflows; a write into a full FIFO is a design error, flagged by a simulation assertion.
- RUN, output side:
  - FIFO pops when non-empty and (WriteReq=0 or WriteReq&Ack this cycle).
  - FIFO has first-word fall-through: on an empty FIFO, write and pop in the same cycle pass the data through.
  - On pop: WriteReq <= 1, data <= f(word), randAddr <= randAddr+1 (wraps at 2^RAND_ADDR_WIDTH).
  - f by MODE: 0 = word; 1 = (word*OPERAND) mod 2^DW; 2 = word ^ randData; 3 = randData ^ OPERAND. randData is sampled in the pop cycle.
  - On an accepted write, increment the word counter. The write address also increments, except on the last word.
  - With no new pop on an accepted write, WriteReq drops.
  - When the word counter reaches LENGTH, go to WRITE_STATUS.
- WRITE_STATUS:
  - Issue a single write of STATUS to address 3: CmdReq=1, WriteEn=1, WriteData = {1'b1, MODE, 29-bit words written}.
  - On Ack, drop CmdReq/WriteEn, pulse userRunClear for one cycle, return to IDLE.
- Throughput: 1 word/cycle sustained when Ack is held high; latency from first input read accept to first output WriteReq = memory latency + 1 cycle.
- Address-width truncation: LENGTH is compared at full 32 bits for the counter and truncated for the addresses. LENGTH > 2^OUTMEM_ADDRESS_WIDTH wraps the output address.

Test Plan:
1. MODE=0, LENGTH=8, input 0x10..0x17, Acks always high -> output addr 0..7 = 0x10..0x17; STATUS=0x80000008 written to addr3; userRunClear pulses once.
2. MODE=1, OPERAND=3, BYTE_WIDTH=1, input 0x90 -> output 0xB0 (0x1B0 mod 256).
3. MODE=2, randData=0xA5 at each randAddr, input 0x0F x4 -> outputs 0xAA; randAddr ends at 4.
4. LENGTH=20, D=4, input Ack random 50%, output Ack stalled 30 cycles -> no FIFO overflow, pending+count <= 4, all 20 words in order.
5. LENGTH=0 -> no memory requests, STATUS=0x80000000 (MODE=0), run cleared.
6. Reset asserted mid-RUN after 5 words -> all outputs 0 next cycle, no STATUS write; a new run with LENGTH=3 completes correctly.
